prpg_scan_driver: RTL and testbench
===================================

PRPG_SCAN_DRIVER -- requirements
Module: prpg_scan_driver

Interface
REQ-001 The block SHALL have parameter PRPG_Size, default 181, giving the PRPG width, equal to the SISA width.
REQ-002 The block SHALL have parameter Chain_Len, default 16, giving the shift cycles per pattern (>=1).
REQ-003 The block SHALL have parameter Pattern_Cnt, default 100, giving the number of patterns per session (>=1).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is sampled on its rising edge.
REQ-005 Port internalRst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port start, input, 1 bit: session request, sampled only in IDLE.
REQ-007 Ports PRPG_Poly and PRPG_Seed, inputs, PRPG_Size bits each: feedback taps and initial state, held static during a session.
REQ-008 Ports SISA_Sig and Golden_Sig, inputs, PRPG_Size bits each: live SISA signature and expected signature.
REQ-009 Port Si, output, 1 bit: scan-in bit to the chain; it equals PRPG bit 0 in SHIFT and 0 elsewhere.
REQ-010 Port Scan_En, output, 1 bit: chain shift enable.
REQ-011 Port Capture, output, 1 bit: one-cycle functional capture pulse.
REQ-012 Port SISA_En, output, 1 bit: compaction enable to the SISA.
REQ-013 Port SISA_Rst, output, 1 bit: active-high one-cycle SISA reseed pulse.
REQ-014 Ports busy, done and pass, outputs, 1 bit each: session status.

Function
REQ-015 The PRPG SHALL be an internal-XOR LFSR: bit N-1 <= bit0; bit i <= (bit0 & PRPG_Poly[i]) ^ bit i+1; it advances only in SHIFT.
REQ-016 The FSM SHALL have exactly the states IDLE, LOAD, SHIFT, CAPTURE, UNLOAD, COMPARE and DONE.
REQ-017 IDLE->LOAD when start=1; in LOAD the PRPG loads PRPG_Seed, the pattern counter and the shift counter clear, and SISA_Rst=1 for that cycle.
REQ-018 LOAD->SHIFT unconditionally; SHIFT SHALL last exactly Chain_Len cycles with Scan_En=1.
REQ-019 SISA_En SHALL be 0 during pattern 0's shift (unknown initial chain content) and 1 during every later shift and during UNLOAD.
REQ-020 SHIFT->CAPTURE after Chain_Len cycles; CAPTURE lasts 1 cycle with Capture=1, Scan_En=0 and the PRPG held, then the pattern counter increments.
REQ-021 CAPTURE->SHIFT while patterns completed < Pattern_Cnt; CAPTURE->UNLOAD when equal.
REQ-022 UNLOAD SHALL last Chain_Len cycles with Scan_En=1, Si=0 and the PRPG held, then go to COMPARE.
REQ-023 COMPARE SHALL last 1 cycle, register pass = (SISA_Sig == Golden_Sig), then go to DONE.
REQ-024 In DONE, done=1 and pass stays stable; start=1 SHALL go to LOAD, which clears done and pass.
REQ-025 busy SHALL be 1 in LOAD through COMPARE; start SHALL be ignored while busy=1.
REQ-026 Latency from the start sample edge to done rising SHALL be 1 + Pattern_Cnt*(Chain_Len+1) + Chain_Len + 1 cycles.
REQ-027 Counters SHALL be $clog2(max+1) bits wide and SHALL never wrap within a session.
REQ-028 An all-zero PRPG_Seed SHALL get no special handling: the PRPG stays zero and Si stays 0.

Reset
REQ-029 Asserting internalRst_n=0 SHALL at once force IDLE, PRPG=PRPG_Seed, counters 0, and Si, Scan_En, Capture, SISA_En, SISA_Rst, busy, done and pass all 0.
REQ-030 Reset during any state SHALL abort the session; no done or pass is produced for it.

Structure
REQ-031 The FSM state enum and the counter-width helper function SHALL live in the shared package stump_pkg.
REQ-032 The LFSR SHALL be one sub-module named prpg, with ports clk, internalRst_n, PRPG_En, PRPG_Load, PRPG_Poly, PRPG_Seed and PRPG_Out.

Verification
REQ-033 Set PRPG_Size=4, Poly=4'b0100, Seed=4'b0001, Chain_Len=15 -> pattern-0 Si sequence is 1,0,0,1,1,0,1,0,1,1,1,1,0,0,0, and the PRPG state repeats with period 15.
REQ-034 Set Chain_Len=8, Pattern_Cnt=3 and pulse start -> done rises exactly 37 cycles after the start edge; there are exactly 3 Capture pulses, one every 9 cycles.
REQ-035 Check SISA_En over the session -> it is low for the first 8 SHIFT cycles, then high for exactly 2*8+8=24 cycles.
REQ-036 Set Golden_Sig equal to SISA_Sig, then repeat with one bit flipped -> pass=1 first, pass=0 second; done=1 in both runs.
REQ-037 Assert internalRst_n=0 in the middle of a session -> all outputs are 0 in the same cycle, the FSM is in IDLE, and a later start runs a full-length session.
REQ-038 Pulse start while busy=1 -> no effect, and the latency is unchanged.

Source files
------------

// File: rtl/stump_pkg.sv
// Types and helpers shared by the STUMPS scan-driver blocks.
package stump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPTURE,
    UNLOAD,
    COMPARE,
    DONE
  } state_e;

  // Bits needed to hold every value from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/prpg.sv
// Internal-XOR LFSR pattern generator with seed load and advance enable.
module prpg #(
  parameter int PRPG_Size = 181
) (
  input  logic                 clk,
  input  logic                 internalRst_n,
  input  logic                 PRPG_En,
  input  logic                 PRPG_Load,
  input  logic [PRPG_Size-1:0] PRPG_Poly,
  input  logic [PRPG_Size-1:0] PRPG_Seed,
  output logic [PRPG_Size-1:0] PRPG_Out
);

  logic [PRPG_Size-1:0] lfsr_next;
  logic                 unused_poly_msb;

  // The top tap is implied: bit 0 always feeds the MSB, so Poly's MSB carries no information.
  assign unused_poly_msb = PRPG_Poly[PRPG_Size-1];

  always_comb begin
    lfsr_next[PRPG_Size-1] = PRPG_Out[0];
    for (int i = 0; i < PRPG_Size - 1; i++) begin
      lfsr_next[i] = (PRPG_Out[0] & PRPG_Poly[i]) ^ PRPG_Out[i+1];
    end
  end

  // NOTE: the reset value is the live seed input, so reset and LOAD leave the same state.
  always_ff @(posedge clk or negedge internalRst_n) begin
    if (!internalRst_n) begin
      PRPG_Out <= PRPG_Seed;
    end else if (PRPG_Load) begin
      PRPG_Out <= PRPG_Seed;
    end else if (PRPG_En) begin
      PRPG_Out <= lfsr_next;
    end
  end

endmodule

// File: rtl/prpg_scan_driver.sv
// STUMPS BIST session controller: shifts PRPG patterns into the chain, captures, unloads into the SISA, checks the signature.
module prpg_scan_driver
  import stump_pkg::*;
#(
  parameter int PRPG_Size   = 181,
  parameter int Chain_Len   = 16,
  parameter int Pattern_Cnt = 100
) (
  input  logic                 clk,
  input  logic                 internalRst_n,
  input  logic                 start,
  input  logic [PRPG_Size-1:0] PRPG_Poly,
  input  logic [PRPG_Size-1:0] PRPG_Seed,
  input  logic [PRPG_Size-1:0] SISA_Sig,
  input  logic [PRPG_Size-1:0] Golden_Sig,
  output logic                 Si,
  output logic                 Scan_En,
  output logic                 Capture,
  output logic                 SISA_En,
  output logic                 SISA_Rst,
  output logic                 busy,
  output logic                 done,
  output logic                 pass
);

  localparam int SHIFT_W = cnt_width(Chain_Len);
  localparam int PAT_W   = cnt_width(Pattern_Cnt);
  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(Chain_Len - 1);
  localparam logic [PAT_W-1:0]   PAT_LAST   = PAT_W'(Pattern_Cnt - 1);

  state_e               state_q, state_d;
  logic [SHIFT_W-1:0]   shift_cnt;
  logic [PAT_W-1:0]     pat_cnt;
  logic                 shift_last;
  logic                 prpg_en, prpg_load;
  logic [PRPG_Size-1:0] prpg_out;
  logic                 unused_prpg_bits;

  prpg #(.PRPG_Size(PRPG_Size)) u_prpg (
    .clk          (clk),
    .internalRst_n(internalRst_n),
    .PRPG_En      (prpg_en),
    .PRPG_Load    (prpg_load),
    .PRPG_Poly    (PRPG_Poly),
    .PRPG_Seed    (PRPG_Seed),
    .PRPG_Out     (prpg_out)
  );

  // Only bit 0 is scanned out; the rest of the register is internal LFSR state.
  assign unused_prpg_bits = ^prpg_out[PRPG_Size-1:0];
  assign shift_last       = (shift_cnt == SHIFT_LAST);
  assign Si               = (state_q == SHIFT) & prpg_out[0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge internalRst_n) begin
    if (!internalRst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    Scan_En   = 1'b0;
    Capture   = 1'b0;
    SISA_En   = 1'b0;
    SISA_Rst  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    prpg_en   = 1'b0;
    prpg_load = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        prpg_load = 1'b1;
        SISA_Rst  = 1'b1;
        state_d   = SHIFT;
      end
      SHIFT: begin
        Scan_En = 1'b1;
        prpg_en = 1'b1;
        // Pattern 0 shifts out whatever the chain powered up with, so it must not reach the SISA.
        SISA_En = (pat_cnt != '0);
        if (shift_last) state_d = CAPTURE;
      end
      CAPTURE: begin
        Capture = 1'b1;
        state_d = (pat_cnt == PAT_LAST) ? UNLOAD : SHIFT;
      end
      UNLOAD: begin
        Scan_En = 1'b1;
        SISA_En = 1'b1;
        if (shift_last) state_d = COMPARE;
      end
      COMPARE: state_d = DONE;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_d = LOAD;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge internalRst_n) begin
    if (!internalRst_n) begin
      shift_cnt <= '0;
      pat_cnt   <= '0;
      pass      <= 1'b0;
    end else begin
      // pass drops on the edge that enters LOAD, so a new session never shows a stale verdict.
      if (state_d == LOAD) begin
        pass <= 1'b0;
      end else if (state_q == COMPARE) begin
        pass <= (SISA_Sig == Golden_Sig);
      end
      case (state_q)
        LOAD: begin
          shift_cnt <= '0;
          pat_cnt   <= '0;
        end
        SHIFT, UNLOAD: shift_cnt <= shift_last ? '0 : shift_cnt + 1'b1;
        CAPTURE:       pat_cnt   <= pat_cnt + 1'b1;
        default:       ;
      endcase
    end
  end

endmodule

// File: tb/tb_prpg_scan_driver.sv
// Bench for prpg_scan_driver: small-PRPG instance against a session model, plus an 8x3 instance for timing corners.
module tb_prpg_scan_driver;

  localparam int A_N   = 4;
  localparam int A_L   = 15;
  localparam int A_P   = 2;
  localparam int A_LAT = 1 + A_P * (A_L + 1) + A_L + 1;
  localparam int B_N   = 16;
  localparam int B_L   = 8;
  localparam int B_P   = 3;

  logic clk = 1'b0;
  logic internalRst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic           start_a = 1'b0;
  logic [A_N-1:0] poly_a = '0, seed_a = '0, sisa_a = '0, gold_a = '0;
  logic si_a, scan_en_a, capture_a, sisa_en_a, sisa_rst_a, busy_a, done_a, pass_a;

  logic           start_b = 1'b0;
  logic [B_N-1:0] poly_b = 16'hB400, seed_b = 16'hACE1, sisa_b = '0, gold_b = '0;
  logic si_b, scan_en_b, capture_b, sisa_en_b, sisa_rst_b, busy_b, done_b, pass_b;

  wire [7:0] outs_a = {si_a, scan_en_a, capture_a, sisa_en_a, sisa_rst_a, busy_a, done_a, pass_a};
  wire [7:0] outs_b = {si_b, scan_en_b, capture_b, sisa_en_b, sisa_rst_b, busy_b, done_b, pass_b};

  prpg_scan_driver #(.PRPG_Size(A_N), .Chain_Len(A_L), .Pattern_Cnt(A_P)) dut_a (
    .clk(clk), .internalRst_n(internalRst_n), .start(start_a),
    .PRPG_Poly(poly_a), .PRPG_Seed(seed_a), .SISA_Sig(sisa_a), .Golden_Sig(gold_a),
    .Si(si_a), .Scan_En(scan_en_a), .Capture(capture_a), .SISA_En(sisa_en_a),
    .SISA_Rst(sisa_rst_a), .busy(busy_a), .done(done_a), .pass(pass_a)
  );

  prpg_scan_driver #(.PRPG_Size(B_N), .Chain_Len(B_L), .Pattern_Cnt(B_P)) dut_b (
    .clk(clk), .internalRst_n(internalRst_n), .start(start_b),
    .PRPG_Poly(poly_b), .PRPG_Seed(seed_b), .SISA_Sig(sisa_b), .Golden_Sig(gold_b),
    .Si(si_b), .Scan_En(scan_en_b), .Capture(capture_b), .SISA_En(sisa_en_b),
    .SISA_Rst(sisa_rst_b), .busy(busy_b), .done(done_b), .pass(pass_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LFSR step as a right shift plus a conditional XOR mask (MSB tap always present).
  function automatic logic [A_N-1:0] lfsr_step(input logic [A_N-1:0] s, input logic [A_N-1:0] poly);
    logic [A_N-1:0] mask;
    mask = poly;
    mask[A_N-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  // One full session on dut_a; every cycle's outputs are compared with the phase derived from the cycle index.
  task automatic run_session_a(input logic [A_N-1:0] poly, input logic [A_N-1:0] seed,
                               input logic flip, input logic exp_pass,
                               output logic [0:A_L-1] si0, output logic [0:A_L-1] si1);
    logic [A_N-1:0] s;
    logic [7:0] exp;
    logic shift_c, cap_c, unl_c;
    int u, pat, k;
    si0 = '0;
    si1 = '0;
    poly_a = poly;
    seed_a = seed;
    sisa_a = A_N'($urandom);
    gold_a = flip ? (sisa_a ^ (A_N'(1) << $urandom_range(A_N - 1, 0))) : sisa_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    s = seed;
    for (int t = 0; t <= A_LAT; t++) begin
      shift_c = 1'b0;
      cap_c   = 1'b0;
      pat     = 0;
      k       = 0;
      if (t >= 1 && t <= A_P * (A_L + 1)) begin
        u       = t - 1;
        pat     = u / (A_L + 1);
        k       = u % (A_L + 1);
        shift_c = (k < A_L);
        cap_c   = (k == A_L);
      end
      unl_c = (t > A_P * (A_L + 1)) && (t <= A_P * (A_L + 1) + A_L);
      exp = {shift_c & s[0], shift_c | unl_c, cap_c, (shift_c && pat > 0) || unl_c,
             t == 0, t < A_LAT, t == A_LAT, (t == A_LAT) & exp_pass};
      if (shift_c && pat == 0) si0[k] = si_a;
      if (shift_c && pat == 1) si1[k] = si_a;
      check($sformatf("a_cyc%0d", t), {24'b0, outs_a}, {24'b0, exp});
      if (shift_c) s = lfsr_step(s, poly);
      if (t != A_LAT) tick();
    end
    tick();
    check("a_done_hold", {30'b0, done_a, pass_a}, {30'b0, 1'b1, exp_pass});
  endtask

  // One session on dut_b measuring latency, capture spacing and SISA_En profile; optionally pokes start mid-session.
  task automatic run_session_b(input logic flip, input int poke_at, input string tag);
    int lat, ncap, first_cap, last_cap, gap_bad, en_hi, en_early, t;
    sisa_b = B_N'($urandom);
    gold_b = flip ? (sisa_b ^ (B_N'(1) << $urandom_range(B_N - 1, 0))) : sisa_b;
    lat = -1; ncap = 0; first_cap = -1; last_cap = -1; gap_bad = 0; en_hi = 0; en_early = 0; t = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    while (t < 200 && lat < 0) begin
      if (done_b) lat = t;
      if (capture_b) begin
        if (ncap == 0) first_cap = t;
        else if (t - last_cap != B_L + 1) gap_bad++;
        last_cap = t;
        ncap++;
      end
      if (sisa_en_b) begin
        en_hi++;
        if (t <= B_L) en_early++;
      end
      start_b = (t == poke_at);
      tick();
      t++;
    end
    start_b = 1'b0;
    check({tag, "_latency"}, lat, 37);
    check({tag, "_captures"}, ncap, 3);
    check({tag, "_first_capture"}, first_cap, 1 + B_L);
    check({tag, "_capture_gap"}, gap_bad, 0);
    check({tag, "_sisa_en_pat0"}, en_early, 0);
    check({tag, "_sisa_en_high"}, en_hi, 2 * B_L + B_L);
    check({tag, "_pass"}, {30'b0, done_b, pass_b}, {30'b0, 1'b1, !flip});
  endtask

  typedef struct {
    logic [A_N-1:0] poly;
    logic [A_N-1:0] seed;
    logic           flip;
    logic           exp_pass;
    logic [0:A_L-1] exp_si;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    logic [0:A_L-1] si0, si1;

    vecs[0] = '{4'b0100, 4'b0001, 1'b0, 1'b1, 15'b100110101111000};
    vecs[1] = '{4'b0100, 4'b0001, 1'b1, 1'b0, 15'b100110101111000};
    vecs[2] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 15'b000000000000000};
    vecs[3] = '{4'b0100, 4'b1000, 1'b1, 1'b0, 15'b000100110101111};

    #12;
    check("reset_outs_a", {24'b0, outs_a}, 32'd0);
    check("reset_outs_b", {24'b0, outs_b}, 32'd0);
    @(negedge clk);
    internalRst_n = 1'b1;
    tick();
    check("idle_outs_a", {24'b0, outs_a}, 32'd0);
    check("idle_outs_b", {24'b0, outs_b}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_session_a(vecs[i].poly, vecs[i].seed, vecs[i].flip, vecs[i].exp_pass, si0, si1);
      check($sformatf("vec%0d_si_pat0", i), {17'b0, si0}, {17'b0, vecs[i].exp_si});
      check($sformatf("vec%0d_si_pat1_period", i), {17'b0, si1}, {17'b0, vecs[i].exp_si});
    end

    for (int r = 0; r < 4; r++) begin
      logic flip;
      flip = 1'($urandom);
      run_session_a(A_N'($urandom), A_N'($urandom), flip, !flip, si0, si1);
    end

    run_session_b(1'b0, 5, "b_golden_match");
    run_session_b(1'b1, 30, "b_golden_flip");

    // Abort both instances mid-session and confirm outputs drop before the next clock edge.
    start_a = 1'b1;
    start_b = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (20) tick();
    #2 internalRst_n = 1'b0;
    #1;
    check("midrst_outs_a", {24'b0, outs_a}, 32'd0);
    check("midrst_outs_b", {24'b0, outs_b}, 32'd0);
    @(negedge clk);
    internalRst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post_rst_idle_a%0d", c), {24'b0, outs_a}, 32'd0);
      check($sformatf("post_rst_idle_b%0d", c), {24'b0, outs_b}, 32'd0);
    end
    run_session_a(4'b0100, 4'b0001, 1'b0, 1'b1, si0, si1);
    check("post_rst_si_pat0", {17'b0, si0}, {17'b0, 15'b100110101111000});
    run_session_b(1'b0, -1, "b_post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
